// File: rtl/sdffe_pipe_m.sv
// ---------------------------------------------------------------------------
// sdffe_pipe_m
// DEPTH-stage delay line of synchronous-reset, enable-gated flip-flops, each
// stage carrying a valid bit. A registered up/down counter tracks how many
// stages hold valid data, and EMPTY flags a drained pipe.
//
// EN advances the pipe when EN == EN_POLARITY. SRST is synchronous and
// active-high, and it takes priority over everything else.
//
// Optional feature: define SDFFE_PIPE_FLUSH_EN to add a synchronous FLUSH
// input. FLUSH clears every valid bit and COUNT but leaves the data stages
// untouched. Priority is SRST > FLUSH > EN.
// ---------------------------------------------------------------------------
module sdffe_pipe_m #(
   parameter int   WIDTH       = 8,
   parameter int   DEPTH       = 3,
   parameter logic EN_POLARITY = 1'b0,
   parameter       SRST_VALUE  = 8'hA5,
   parameter int   CW          = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             SRST,
`ifdef SDFFE_PIPE_FLUSH_EN
   input  logic             FLUSH,
`endif
   input  logic             EN,
   input  logic [WIDTH-1:0] D,
   input  logic             D_VALID,
   output logic [WIDTH-1:0] Q,
   output logic             Q_VALID,
   output logic [CW-1:0]    COUNT,
   output logic             EMPTY
);

   // Reset value fitted to the data width (truncated or zero-extended).
   localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(SRST_VALUE);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [CW-1:0]    count_q;
   logic             en_active;

   // An X on EN falls through to "hold", and SRST is tested first anyway.
   assign en_active = (EN == EN_POLARITY);

   // Data path: reset loads SRST_VALUE, advance shifts, otherwise hold.
   // NOTE: the data stages are reset here on purpose because Q must read
   // SRST_VALUE straight after reset. A plain storage array would normally
   // be left unreset.
   always_ff @(posedge CLK) begin
      // NOTE: use non-blocking assignments so every stage samples its
      // neighbour's pre-edge value. Blocking assignments would collapse the
      // shift register into a single stage.
      if (SRST) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_DATA;
      end
`ifdef SDFFE_PIPE_FLUSH_EN
      else if (FLUSH) begin
         // Flush leaves the data where it is.
      end
`endif
      else if (en_active) begin
         stage_q[0] <= D;
         for (int i = DEPTH - 1; i > 0; i--) stage_q[i] <= stage_q[i-1];
      end
   end

   // Control path: the valid bits shift with the data, and COUNT moves by
   // (valid in) - (valid out).
   always_ff @(posedge CLK) begin
      if (SRST) begin
         valid_q <= '0;
         count_q <= '0;
      end
`ifdef SDFFE_PIPE_FLUSH_EN
      else if (FLUSH) begin
         valid_q <= '0;
         count_q <= '0;
      end
`endif
      else if (en_active) begin
         valid_q[0] <= D_VALID;
         for (int i = DEPTH - 1; i > 0; i--) valid_q[i] <= valid_q[i-1];
         // The outgoing valid bit is the pre-edge value of the last stage.
         case ({D_VALID, valid_q[DEPTH-1]})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign Q       = stage_q[DEPTH-1];
   assign Q_VALID = valid_q[DEPTH-1];
   assign COUNT   = count_q;
   assign EMPTY   = (count_q == '0);

endmodule

// File: tb/tb_sdffe_pipe_m.sv
// ---------------------------------------------------------------------------
// tb_sdffe_pipe_m
// Directed bench for sdffe_pipe_m.
// u_dut: WIDTH=8, DEPTH=3, EN_POLARITY=0, SRST_VALUE=8'hA5.
// u_one: DEPTH=1, WIDTH=4, EN_POLARITY=1, so its reset value truncates to 4'h5.
// A small shift-register model of u_dut provides the COUNT == popcount(valid)
// invariant. The directed steps compare against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sdffe_pipe_m;

   logic       CLK = 1'b0;
   logic       SRST;
   logic       EN;
   logic [7:0] D;
   logic       D_VALID;
`ifdef SDFFE_PIPE_FLUSH_EN
   logic       FLUSH;
`endif

   logic [7:0] Q;
   logic       Q_VALID;
   logic [1:0] COUNT;
   logic       EMPTY;

   logic [3:0] q1;
   logic       q1_valid;
   logic [0:0] count1;
   logic       empty1;

   int checks = 0;
   int errors = 0;

   // Reference state for u_dut.
   logic [7:0] m_data [3];
   logic [2:0] m_valid;

   always #5 CLK = ~CLK;

   sdffe_pipe_m #(.WIDTH(8), .DEPTH(3), .EN_POLARITY(1'b0), .SRST_VALUE(8'hA5)) u_dut (
      .CLK     (CLK),
      .SRST    (SRST),
`ifdef SDFFE_PIPE_FLUSH_EN
      .FLUSH   (FLUSH),
`endif
      .EN      (EN),
      .D       (D),
      .D_VALID (D_VALID),
      .Q       (Q),
      .Q_VALID (Q_VALID),
      .COUNT   (COUNT),
      .EMPTY   (EMPTY)
   );

   sdffe_pipe_m #(.WIDTH(4), .DEPTH(1), .EN_POLARITY(1'b1), .SRST_VALUE(8'hA5)) u_one (
      .CLK     (CLK),
      .SRST    (SRST),
`ifdef SDFFE_PIPE_FLUSH_EN
      .FLUSH   (FLUSH),
`endif
      .EN      (EN),
      .D       (D[3:0]),
      .D_VALID (D_VALID),
      .Q       (q1),
      .Q_VALID (q1_valid),
      .COUNT   (count1),
      .EMPTY   (empty1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare u_dut against the reference model.
   task automatic check_model(input string tag);
      int pc;
      pc = $countones(m_valid);
      check({tag, "_q"},     32'(Q),       32'(m_data[2]));
      check({tag, "_qv"},    32'(Q_VALID), 32'(m_valid[2]));
      check({tag, "_count"}, 32'(COUNT),   32'(pc));
      check({tag, "_empty"}, 32'(EMPTY),   32'(pc == 0));
   endtask

   // Drive one clock edge: set inputs on the falling edge, update the model
   // at the rising edge, and return 1 time unit after the rising edge.
   task automatic step(input logic srst, input logic en, input logic [7:0] d,
                       input logic dv, input logic fl);
      @(negedge CLK);
      SRST    = srst;
      EN      = en;
      D       = d;
      D_VALID = dv;
`ifdef SDFFE_PIPE_FLUSH_EN
      FLUSH   = fl;
`endif
      @(posedge CLK);
      if (srst) begin
         for (int i = 0; i < 3; i++) m_data[i] = 8'hA5;
         m_valid = 3'b000;
      end else if (fl) begin
         m_valid = 3'b000;
      end else if (en === 1'b0) begin
         m_data[2] = m_data[1];
         m_data[1] = m_data[0];
         m_data[0] = d;
         m_valid   = {m_valid[1:0], dv};
      end
      #1;
   endtask

   initial begin
      logic [7:0] hold_d [5];
      logic       hold_v [5];
      logic       alt_qv [8];
      logic [1:0] alt_cnt [8];

      hold_d  = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hE9};
      hold_v  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      alt_qv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      alt_cnt = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};

      SRST = 1'b1; EN = 1'b0; D = 8'hFF; D_VALID = 1'b1;
`ifdef SDFFE_PIPE_FLUSH_EN
      FLUSH = 1'b0;
`endif
      for (int i = 0; i < 3; i++) m_data[i] = 8'h00;
      m_valid = 3'b000;

      // Reset for two edges. The second edge has EN=X, which must not disturb reset.
      step(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
      step(1'b1, 1'bx, 8'hFF, 1'b1, 1'b0);
      check("rst_q",      32'(Q),       32'hA5);
      check("rst_qv",     32'(Q_VALID), 32'h0);
      check("rst_count",  32'(COUNT),   32'h0);
      check("rst_empty",  32'(EMPTY),   32'h1);
      check("rst1_q",     32'(q1),      32'h5);
      check("rst1_qv",    32'(q1_valid), 32'h0);
      check("rst1_count", 32'(count1),  32'h0);
      check("rst1_empty", 32'(empty1),  32'h1);

      // Fill with 11, 22, 33.
      step(1'b0, 1'b0, 8'h11, 1'b1, 1'b0);
      check("fill1_count", 32'(COUNT), 32'h1);
      check("fill1_q",     32'(Q),     32'hA5);
      check("fill1_empty", 32'(EMPTY), 32'h0);
      step(1'b0, 1'b0, 8'h22, 1'b1, 1'b0);
      check("fill2_count", 32'(COUNT), 32'h2);
      step(1'b0, 1'b0, 8'h33, 1'b1, 1'b0);
      check("fill3_q",     32'(Q),       32'h11);
      check("fill3_qv",    32'(Q_VALID), 32'h1);
      check("fill3_count", 32'(COUNT),   32'h3);
      check_model("fill3");
      check("one_hold_q", 32'(q1), 32'h5);

      // A 4th edge with D_VALID=0 drops COUNT to 2.
      step(1'b0, 1'b0, 8'h44, 1'b0, 1'b0);
      check("adv4_q",     32'(Q),     32'h22);
      check("adv4_count", 32'(COUNT), 32'h2);
      check_model("adv4");

      // Refill to COUNT=3. The stages end up as [77v, 66v, 55v].
      step(1'b0, 1'b0, 8'h55, 1'b1, 1'b0);
      check("adv5_q",     32'(Q),       32'h33);
      check("adv5_count", 32'(COUNT),   32'h2);
      step(1'b0, 1'b0, 8'h66, 1'b1, 1'b0);
      check("adv6_q",     32'(Q),       32'h44);
      check("adv6_qv",    32'(Q_VALID), 32'h0);
      check("adv6_count", 32'(COUNT),   32'h2);
      step(1'b0, 1'b0, 8'h77, 1'b1, 1'b0);
      check("adv7_q",     32'(Q),       32'h55);
      check("adv7_count", 32'(COUNT),   32'h3);
      check_model("adv7");

      // EN inactive for 5 edges with D changing: u_dut holds while u_one
      // (active-high EN) advances on each edge.
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, hold_d[i], hold_v[i], 1'b0);
         check($sformatf("hold%0d_q", i),     32'(Q),        32'h55);
         check($sformatf("hold%0d_qv", i),    32'(Q_VALID),  32'h1);
         check($sformatf("hold%0d_count", i), 32'(COUNT),    32'h3);
         check($sformatf("one%0d_q", i),      32'(q1),       32'(hold_d[i][3:0]));
         check($sformatf("one%0d_qv", i),     32'(q1_valid), 32'(hold_v[i]));
         check($sformatf("one%0d_count", i),  32'(count1),   32'(hold_v[i]));
         check($sformatf("one%0d_empty", i),  32'(empty1),   32'(!hold_v[i]));
      end

      // Reset with EN active while full: D=99 must not be captured.
      step(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
      check("srst_full_q",     32'(Q),       32'hA5);
      check("srst_full_qv",    32'(Q_VALID), 32'h0);
      check("srst_full_count", 32'(COUNT),   32'h0);
      check("srst_full_empty", 32'(EMPTY),   32'h1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("srst_nocap_q", 32'(Q), 32'hA5);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("srst_drain_q", 32'(Q), 32'h00);
      check_model("srst_drain");

      // Alternate D_VALID 1,0,1,... with EN active on every edge.
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 8'(8'hC0 + i), (i % 2 == 0), 1'b0);
         check($sformatf("alt%0d_qv", i),    32'(Q_VALID), 32'(alt_qv[i]));
         check($sformatf("alt%0d_count", i), 32'(COUNT),   32'(alt_cnt[i]));
         check_model($sformatf("alt%0d", i));
      end
      check("alt_last_q", 32'(Q), 32'hC5);

`ifdef SDFFE_PIPE_FLUSH_EN
      // Refill with 11, 22, 33, then flush with EN active: valid clears and data holds.
      step(1'b0, 1'b0, 8'h11, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h22, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h33, 1'b1, 1'b0);
      check("preflush_count", 32'(COUNT), 32'h3);
      step(1'b0, 1'b0, 8'h44, 1'b1, 1'b1);
      check("flush_q",     32'(Q),       32'h11);
      check("flush_qv",    32'(Q_VALID), 32'h0);
      check("flush_count", 32'(COUNT),   32'h0);
      check("flush_empty", 32'(EMPTY),   32'h1);
      step(1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
      check("postflush_q",  32'(Q),       32'h22);
      check("postflush_qv", 32'(Q_VALID), 32'h0);
      check_model("postflush");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
